// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Moore sequencing controller for the multicycle RV32I core. It steps each
//   instruction through fetch, decode and execute states. Along the way it
//   steers the shared ALU, the unified memory port and the register file.
//   Memory accesses wait on MemReady. A watchdog sends the FSM to a sticky
//   FAULT state if MemReady stays low for too long. An illegal opcode also
//   ends in FAULT.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   op[6:0]      opcode from the instruction register
//   BranchTaken  branch compare result, used in BEQ
//   MemReady     memory finishes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite      datapath strobes/selects
//   ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0], ImmSrc[2:0]
//   Fault        sticky fault flag (high while in FAULT)
//   State[3:0]   current state encoding, for debug
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, PC <- PC+4 when memory is ready
// DECODE   | ALUOut <- OldPC + imm, dispatch on opcode
// MEMADR   | ALUOut <- rs1 + imm (load/store address)
// MEMREAD  | load data from ALUOut address
// MEMWB    | rd <- loaded data
// MEMWRITE | store rs2 to ALUOut address, held until ready
// EXECR    | ALUOut <- rs1 op rs2
// EXECI    | ALUOut <- rs1 op imm
// ALUWB    | rd <- ALUOut
// BEQ      | compare rs1/rs2, PC <- branch target when taken
// JAL      | PC <- target, ALUOut <- OldPC+4
// JALR1    | ALUOut <- rs1 + imm
// JALR2    | PC <- ALUOut, ALUOut <- OldPC+4
// LUI      | ALUOut <- 0 + imm
// FAULT    | illegal opcode or memory timeout, held until reset

module multicycle_ctrl_fsm #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       BranchTaken,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       Fault,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_FAULT    = 4'd14
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    // Last count value before a timeout. When the watchdog is disabled this
    // value is never compared.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             waiting;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        waiting    = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE)) && !MemReady;
        wait_cnt_d = waiting ? (wait_cnt_q + CNT_W'(1)) : '0;
        // A cycle with MemReady high is never a wait cycle, so a ready
        // response on the last allowed cycle still completes the access.
        timeout    = (WAIT_LIMIT != 0) && waiting && (wait_cnt_q == LIMIT_M1);
    end

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady)     state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR1;
                    OP_AUIPC:     state_d = S_ALUWB;
                    OP_LUI:       state_d = S_LUI;
                    OP_NOP:       state_d = S_FETCH;
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady)     state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady)     state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = BranchTaken;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALR2;
            end
            S_JALR2: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // Strobes must stay quiet during the reset cycle, whatever the state.
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:            ImmSrc = 3'b001;
            OP_B:             ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_AUIPC, OP_LUI: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    assign Fault = (state_q == S_FAULT);
    assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    localparam int LIMIT = 4;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, AU = 7'b0010111, LU = 7'b0110111,
                           NP = 7'b0000000;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                   MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9,
                   JAL = 10, JALR1 = 11, JALR2 = 12, LUI = 13, FLT = 14;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [2:0] imm;
        logic       regw;
        logic       flt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       BranchTaken, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Fault;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] State;

    multicycle_ctrl_fsm #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .BranchTaken(BranchTaken),
        .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .Fault(Fault), .State(State)
    );

    always #5 clk = ~clk;

    obs_t       exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [6:0] cur_op;
    int         fault_hold = 3;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == SW)                 return 3'b001;
        if (o == BR)                 return 3'b010;
        if (o == JL)                 return 3'b011;
        if (o == AU || o == LU)      return 3'b100;
        return 3'b000;
    endfunction

    // Expected datapath controls for one cycle, taken from the state table.
    function automatic obs_t expect_of(input int st, input logic [6:0] o,
                                       input logic mr, input logic br,
                                       input logic rst);
        obs_t e;
        e     = '0;
        e.st  = 4'(st);
        e.imm = imm_of(o);
        case (st)
            FETCH:    begin e.b = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
            DECODE:   begin e.a = 2'b01; e.b = 2'b01; end
            MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
            MEMREAD:  e.adr = 1'b1;
            MEMWB:    begin e.res = 2'b01; e.regw = 1'b1; end
            MEMWRITE: begin e.adr = 1'b1; e.memw = 1'b1; end
            EXECR:    begin e.a = 2'b10; e.aop = 2'b10; end
            EXECI:    begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
            ALUWB:    e.regw = 1'b1;
            BEQ:      begin e.a = 2'b10; e.aop = 2'b01; e.pcw = br; end
            JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
            JALR1:    begin e.a = 2'b10; e.b = 2'b01; end
            JALR2:    begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
            LUI:      begin e.a = 2'b11; e.b = 2'b01; end
            FLT:      e.flt = 1'b1;
            default:  ;
        endcase
        if (rst) begin
            e.pcw = 1'b0; e.memw = 1'b0; e.irw = 1'b0; e.regw = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle and record what the DUT should present during it.
    task automatic cyc_in(input int st, input logic mr, input logic br, input logic rst);
        op          = cur_op;
        MemReady    = mr;
        BranchTaken = br;
        reset       = rst;
        exp_q.push_back(expect_of(st, cur_op, mr, br, rst));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int st);
        cyc_in(st, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // Memory-style state: n_low cycles with MemReady low, then one ready cycle,
    // unless the low run reaches the watchdog limit.
    task automatic wait_phase(input int st, input int n_low, output bit to);
        for (int i = 0; i < n_low && i < LIMIT; i++)
            cyc_in(st, 1'b0, 1'($urandom), 1'b0);
        if (n_low >= LIMIT) begin
            to = 1'b1;
        end else begin
            cyc_in(st, 1'b1, 1'($urandom), 1'b0);
            to = 1'b0;
        end
    endtask

    task automatic fault_seq();
        for (int i = 0; i < fault_hold; i++) begin
            cur_op = 7'($urandom);
            cyc(FLT);
        end
        cyc_in(FLT, 1'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic instr(input logic [6:0] opc, input int fw, input int mw, input logic br);
        bit to;
        cur_op = 7'($urandom);
        wait_phase(FETCH, fw, to);
        if (to) begin fault_seq(); return; end
        cur_op = opc;
        cyc(DECODE);
        case (opc)
            LW: begin
                cyc(MEMADR);
                wait_phase(MEMREAD, mw, to);
                if (to) fault_seq(); else cyc(MEMWB);
            end
            SW: begin
                cyc(MEMADR);
                wait_phase(MEMWRITE, mw, to);
                if (to) fault_seq();
            end
            RT: begin cyc(EXECR); cyc(ALUWB); end
            IT: begin cyc(EXECI); cyc(ALUWB); end
            BR: cyc_in(BEQ, 1'($urandom), br, 1'b0);
            JL: begin cyc(JAL); cyc(ALUWB); end
            JR: begin cyc(JALR1); cyc(JALR2); cyc(ALUWB); end
            AU: cyc(ALUWB);
            LU: begin cyc(LUI); cyc(ALUWB); end
            NP: ;
            default: fault_seq();
        endcase
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return 0;
        if (r < 6) return 1;
        if (r < 8) return 2;
        if (r < 9) return 3;
        return 4;
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] legal [11];
        logic [6:0] o;
        legal = '{LW, SW, RT, IT, BR, JL, JR, AU, LU, NP, LW};
        if ($urandom_range(0, 19) == 0) begin
            do o = 7'($urandom);
            while (o == LW || o == SW || o == RT || o == IT || o == BR || o == JL ||
                   o == JR || o == AU || o == LU || o == NP);
            return o;
        end
        return legal[$urandom_range(0, 10)];
    endfunction

    // Monitor: every cycle with an outstanding expectation is compared.
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUOp, ImmSrc, RegWrite, Fault};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ctrl_outputs t=%0t exp_state=%0d: actual=%h required=%h (state act=%0d)",
                         $time, e.st, a, e, a.st);
            end
        end
    end

    initial begin
        cur_op      = 7'd0;
        op          = 7'd0;
        MemReady    = 1'b0;
        BranchTaken = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        cyc_in(FETCH, 1'b1, 1'b1, 1'b1);        // reset state, strobes forced low

        instr(LW, 0, 0, 1'b0);                  // 0,1,2,3,4,0
        instr(SW, 0, 3, 1'b0);                  // MemWrite held 4 cycles
        instr(BR, 0, 0, 1'b1);
        instr(BR, 0, 0, 1'b0);
        fault_hold = 20;
        instr(7'b1111111, 0, 0, 1'b0);          // illegal -> FAULT, reset
        fault_hold = 3;
        instr(RT, 4, 0, 1'b0);                  // FETCH timeout
        instr(RT, 3, 0, 1'b0);                  // ready on last allowed cycle
        instr(JR, 0, 0, 1'b0);                  // 0,1,11,12,8,0
        instr(NP, 1, 0, 1'b0);
        instr(LW, 2, 4, 1'b0);                  // MEMREAD timeout

        // Reset in the middle of a stalled store; the wait count must clear.
        cur_op = 7'($urandom);
        cyc_in(FETCH, 1'b1, 1'b0, 1'b0);
        cur_op = SW;
        cyc(DECODE);
        cyc(MEMADR);
        cyc_in(MEMWRITE, 1'b0, 1'b0, 1'b0);
        cyc_in(MEMWRITE, 1'b0, 1'b0, 1'b0);
        cyc_in(MEMWRITE, 1'b0, 1'b0, 1'b1);
        instr(IT, 3, 0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            fault_hold = int'($urandom_range(1, 5));
            instr(rand_op(), rand_wait(), rand_wait(), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
